async_queue_sink_dmctrl: RTL and testbench

ASYNC_QUEUE_SINK_DMCTRL -- requirements
Module: async_queue_sink_dmctrl

---
 rtl/async_queue_sink_dmctrl.sv | 124 ++++++++++++
 tb/tb_async_queue_sink_dmctrl.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/async_queue_sink_dmctrl.sv
// Sink half of a single-entry asynchronous queue carrying debug-module control
// requests. Synchronizes the source's Gray write index and liveness, presents
// the entry on a valid/ready port and returns a Gray read index.
module async_queue_sink_dmctrl #(
  parameter int unsigned SYNC_STAGES = 3
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       io_async_mem_0_resumereq,
  input  logic       io_async_mem_0_ackhavereset,
  input  logic       io_async_mem_0_hasel,
  input  logic       io_async_mem_0_hamask_0,
  input  logic       io_async_mem_0_hrmask_0,
  input  logic [9:0] io_async_mem_0_hartsel,
  input  logic       io_async_widx,
  input  logic       io_async_safe_widx_valid,
  input  logic       io_async_safe_source_reset_n,
  output logic       io_async_ridx,
  output logic       io_async_safe_ridx_valid,
  output logic       io_async_safe_sink_reset_n,
  input  logic       io_deq_ready,
  output logic       io_deq_valid,
  output logic       io_deq_bits_resumereq,
  output logic       io_deq_bits_ackhavereset,
  output logic       io_deq_bits_hasel,
  output logic       io_deq_bits_hamask_0,
  output logic       io_deq_bits_hrmask_0,
  output logic [9:0] io_deq_bits_hartsel
);

  // Chains tied to source liveness are cleared by either side's reset.
  logic link_rst_n;
  assign link_rst_n = reset_n & io_async_safe_source_reset_n;

  logic [SYNC_STAGES-1:0] extend_q;
  logic [SYNC_STAGES-1:0] source_valid_q;
  logic [SYNC_STAGES-1:0] sink_valid_0_q;
  logic [SYNC_STAGES-1:0] sink_valid_1_q;
  logic [SYNC_STAGES-1:0] widx_q;

  logic        source_ready;
  logic        widx_sync;
  logic        ridx_bin;
  logic        ridx;
  logic        ridx_gray;
  logic        valid;
  logic        valid_reg;
  logic        deq_fire;
  logic [14:0] bits_reg;

  assign source_ready = source_valid_q[SYNC_STAGES-1];
  assign widx_sync    = widx_q[SYNC_STAGES-1];

  // Source liveness stretch: drops the instant the source resets.
  always_ff @(posedge clock or negedge link_rst_n) begin
    if (!link_rst_n) extend_q <= '0;
    else             extend_q <= {extend_q[SYNC_STAGES-2:0], io_async_safe_widx_valid};
  end

  // Re-synchronize the stretched liveness under the sink reset only.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) source_valid_q <= '0;
    else          source_valid_q <= {source_valid_q[SYNC_STAGES-2:0], extend_q[SYNC_STAGES-1]};
  end

  // Sink-alive indication returned to the source, two chains deep.
  always_ff @(posedge clock or negedge link_rst_n) begin
    if (!link_rst_n) begin
      sink_valid_0_q <= '0;
      sink_valid_1_q <= '0;
    end else begin
      sink_valid_0_q <= {sink_valid_0_q[SYNC_STAGES-2:0], 1'b1};
      sink_valid_1_q <= {sink_valid_1_q[SYNC_STAGES-2:0], sink_valid_0_q[SYNC_STAGES-1]};
    end
  end

  // Write index synchronizer.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) widx_q <= '0;
    else          widx_q <= {widx_q[SYNC_STAGES-2:0], io_async_widx};
  end

  // Read pointer advance and entry-pending detection.
  always_comb begin
    deq_fire = io_deq_valid & io_deq_ready;
    ridx     = source_ready ? (ridx_bin ^ deq_fire) : 1'b0;
    valid    = source_ready & (ridx != widx_sync);
  end

  // Read pointer, returned Gray index and output valid registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ridx_bin  <= 1'b0;
      ridx_gray <= 1'b0;
      valid_reg <= 1'b0;
    end else begin
      ridx_bin  <= ridx;
      ridx_gray <= ridx;
      valid_reg <= valid;
    end
  end

  // Payload capture; only meaningful while an entry is pending.
  always_ff @(posedge clock) begin
    if (valid) begin
      bits_reg <= {io_async_mem_0_hartsel, io_async_mem_0_resumereq,
                   io_async_mem_0_ackhavereset, io_async_mem_0_hasel,
                   io_async_mem_0_hamask_0, io_async_mem_0_hrmask_0};
    end
  end

  assign io_deq_valid               = valid_reg & source_ready;
  assign io_async_ridx              = ridx_gray;
  assign io_async_safe_ridx_valid   = sink_valid_1_q[SYNC_STAGES-1];
  assign io_async_safe_sink_reset_n = reset_n;

  assign io_deq_bits_hartsel        = bits_reg[14:5];
  assign io_deq_bits_resumereq      = bits_reg[4];
  assign io_deq_bits_ackhavereset   = bits_reg[3];
  assign io_deq_bits_hasel          = bits_reg[2];
  assign io_deq_bits_hamask_0       = bits_reg[1];
  assign io_deq_bits_hrmask_0       = bits_reg[0];

endmodule

// File: tb/tb_async_queue_sink_dmctrl.sv
// Bench for async_queue_sink_dmctrl: directed scenarios plus a randomized
// transfer phase, checked every cycle against a history-based reference model.
module tb_async_queue_sink_dmctrl;

  localparam int MAXE = 4096;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       mem_resumereq, mem_ackhavereset, mem_hasel, mem_hamask, mem_hrmask;
  logic [9:0] mem_hartsel;
  logic       widx, widx_valid, source_reset_n;
  logic       ridx, ridx_valid, sink_reset_n;
  logic       deq_ready, deq_valid;
  logic       b_resumereq, b_ackhavereset, b_hasel, b_hamask, b_hrmask;
  logic [9:0] b_hartsel;

  async_queue_sink_dmctrl #(.SYNC_STAGES(3)) dut (
    .clock                        (clock),
    .reset_n                      (reset_n),
    .io_async_mem_0_resumereq     (mem_resumereq),
    .io_async_mem_0_ackhavereset  (mem_ackhavereset),
    .io_async_mem_0_hasel         (mem_hasel),
    .io_async_mem_0_hamask_0      (mem_hamask),
    .io_async_mem_0_hrmask_0      (mem_hrmask),
    .io_async_mem_0_hartsel       (mem_hartsel),
    .io_async_widx                (widx),
    .io_async_safe_widx_valid     (widx_valid),
    .io_async_safe_source_reset_n (source_reset_n),
    .io_async_ridx                (ridx),
    .io_async_safe_ridx_valid     (ridx_valid),
    .io_async_safe_sink_reset_n   (sink_reset_n),
    .io_deq_ready                 (deq_ready),
    .io_deq_valid                 (deq_valid),
    .io_deq_bits_resumereq        (b_resumereq),
    .io_deq_bits_ackhavereset     (b_ackhavereset),
    .io_deq_bits_hasel            (b_hasel),
    .io_deq_bits_hamask_0         (b_hamask),
    .io_deq_bits_hrmask_0         (b_hrmask),
    .io_deq_bits_hartsel          (b_hartsel)
  );

  always #5 clock = ~clock;

  int compared   = 0;
  int mismatched = 0;

  // Input history per clock edge; edge index n counts from the first edge.
  bit h_rst [0:MAXE-1];
  bit h_srst[0:MAXE-1];
  bit h_wv  [0:MAXE-1];
  bit h_wi  [0:MAXE-1];
  bit h_rdy [0:MAXE-1];
  int n = -1;

  // Reference state: entries written but not yet consumed, read count.
  logic [14:0] wr_q[$];
  int  reads  = 0;
  bit  vis    = 1'b0;
  bit  exp_dv = 1'b0;
  int  fires  = 0;
  bit  rand_ready = 1'b0;

  function automatic bit rst_at(int k);
    return (k < 0) ? 1'b1 : h_rst[k];
  endfunction
  function automatic bit link_clr_at(int k);
    return rst_at(k) | ((k < 0) ? 1'b1 : h_srst[k]);
  endfunction
  function automatic bit wv_at(int k);
    return (k < 0) ? 1'b0 : h_wv[k];
  endfunction
  function automatic bit wi_at(int k);
    return (k < 0) ? 1'b0 : h_wi[k];
  endfunction

  // A value entering a 3-deep chain at edge k emerges after edge k+2 unless
  // that chain's reset was seen at any of the three edges.
  function automatic bit extend_at(int m);
    return wv_at(m-2) & !link_clr_at(m-2) & !link_clr_at(m-1) & !link_clr_at(m);
  endfunction
  function automatic bit src_ready_at(int m);
    return extend_at(m-3) & !link_clr_at(m-2) & !rst_at(m-2) & !rst_at(m-1) & !rst_at(m);
  endfunction
  function automatic bit sink_alive_at(int m);
    for (int k = m - 5; k <= m; k++) if (link_clr_at(k)) return 1'b0;
    return 1'b1;
  endfunction
  function automatic bit wsync_at(int m);
    return wi_at(m-2) & !rst_at(m-2) & !rst_at(m-1) & !rst_at(m);
  endfunction

  function automatic logic [14:0] deq_bits();
    return {b_hartsel, b_resumereq, b_ackhavereset, b_hasel, b_hamask, b_hrmask};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock edge: log the inputs it samples, advance the model, compare.
  task automatic step();
    bit fire;
    @(posedge clock);
    n++;
    if (n >= MAXE) begin
      $display("FAIL history_overflow observed=%0d expected<%0d", n, MAXE);
      $fatal(1);
    end
    h_rst[n]  = !reset_n;
    h_srst[n] = !source_reset_n;
    h_wv[n]   = widx_valid;
    h_wi[n]   = widx;
    h_rdy[n]  = deq_ready;
    #1;
    if (rst_at(n)) begin
      reads = 0;
      vis   = 1'b0;
      wr_q.delete();
    end else begin
      fire = exp_dv & h_rdy[n];
      if (fire) begin
        fires++;
        if (wr_q.size() > 0) void'(wr_q.pop_front());
      end
      if (!src_ready_at(n-1)) reads = 0;
      else                    reads = reads + int'(fire);
      vis = src_ready_at(n-1) && ((reads % 2) != int'(wsync_at(n-1)));
    end
    if (!src_ready_at(n)) wr_q.delete();
    exp_dv = vis & src_ready_at(n);

    chk("deq_valid",    32'(deq_valid),    32'(exp_dv));
    chk("ridx",         32'(ridx),         32'(reads % 2));
    chk("ridx_valid",   32'(ridx_valid),   32'(sink_alive_at(n)));
    chk("sink_reset_n", 32'(sink_reset_n), 32'(reset_n));
    if (exp_dv)
      chk("deq_bits", 32'(deq_bits()), (wr_q.size() > 0) ? 32'(wr_q[0]) : 32'hFFFF_FFFF);
    if (rand_ready) deq_ready = 1'($urandom % 2);
  endtask

  task automatic steps(input int unsigned cnt);
    for (int unsigned i = 0; i < cnt; i++) step();
  endtask

  // Source side: wait for the queue slot to be free and the sink alive, then write.
  task automatic write_entry(input logic [14:0] p);
    int unsigned waited = 0;
    while (!(ridx === widx && ridx_valid === 1'b1) && waited < 200) begin
      step();
      waited++;
    end
    chk("space_wait_bound", 32'(waited < 200), 32'd1);
    {mem_hartsel, mem_resumereq, mem_ackhavereset, mem_hasel, mem_hamask, mem_hrmask} = p;
    widx = ~widx;
    wr_q.push_back(p);
  endtask

  initial begin
    int f0;
    reset_n = 1'b0; source_reset_n = 1'b1; widx_valid = 1'b1; widx = 1'b0;
    deq_ready = 1'b0;
    {mem_hartsel, mem_resumereq, mem_ackhavereset, mem_hasel, mem_hamask, mem_hrmask} = '0;

    // Reset state, then release with the source alive and idle.
    steps(3);
    reset_n = 1'b1;
    steps(9);

    // Single transfer with ready held high.
    deq_ready = 1'b1;
    f0 = fires;
    write_entry({10'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1});
    steps(8);
    chk("single_fire_count", 32'(fires - f0), 32'd1);

    // Entry held while ready is low, then exactly one fire.
    deq_ready = 1'b0;
    f0 = fires;
    write_entry(15'($urandom));
    steps(24);
    chk("held_no_fire", 32'(fires - f0), 32'd0);
    deq_ready = 1'b1;
    steps(4);
    chk("held_one_fire", 32'(fires - f0), 32'd1);

    // Two back-to-back transfers.
    f0 = fires;
    write_entry(15'($urandom));
    write_entry(15'($urandom));
    steps(10);
    chk("b2b_fires", 32'(fires - f0), 32'd2);
    chk("b2b_ridx_end", 32'(ridx), 32'd0);

    // Randomized traffic with random ready.
    rand_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      write_entry(15'($urandom));
      steps($urandom_range(0, 3));
    end
    rand_ready = 1'b0;
    deq_ready = 1'b1;
    steps(10);

    // Source reset while an entry is pending: entry discarded, no fire.
    deq_ready = 1'b0;
    write_entry(15'($urandom));
    steps(6);
    f0 = fires;
    source_reset_n = 1'b0;
    widx = 1'b0;
    steps(3);
    source_reset_n = 1'b1;
    steps(10);
    deq_ready = 1'b1;
    steps(2);
    chk("srst_no_fire", 32'(fires - f0), 32'd0);
    write_entry(15'($urandom));
    steps(8);
    chk("srst_recovery_fire", 32'(fires - f0), 32'd1);

    // Sink reset asserted between edges mid-transfer.
    write_entry(15'($urandom));
    steps(2);
    #3;
    reset_n = 1'b0;
    widx = 1'b0;
    #1;
    chk("async_rst_deq_valid",    32'(deq_valid),    32'd0);
    chk("async_rst_ridx",         32'(ridx),         32'd0);
    chk("async_rst_ridx_valid",   32'(ridx_valid),   32'd0);
    chk("async_rst_sink_reset_n", 32'(sink_reset_n), 32'd0);
    steps(2);
    reset_n = 1'b1;
    steps(9);
    f0 = fires;
    write_entry(15'($urandom));
    steps(8);
    chk("rst_recovery_fire", 32'(fires - f0), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
